// File: rtl/pcie_tlp_vc_buffer.sv
// Per-VC circular TLP beat buffers with framing/overflow policing on ingress
// and packet-atomic round-robin arbitration on egress.
module pcie_tlp_vc_buffer #(
    parameter  int DATA_WIDTH       = 256,
    parameter  int TLP_HEADER_WIDTH = 128,
    parameter  int NUM_VC           = 2,
    parameter  int DEPTH            = 8,
    localparam int VC_W             = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int CNT_W            = $clog2(DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rx_valid,
    input  logic [VC_W-1:0]             rx_vc,
    input  logic [TLP_HEADER_WIDTH-1:0] rx_header,
    input  logic [DATA_WIDTH-1:0]       rx_data,
    input  logic                        rx_sop,
    input  logic                        rx_eop,
    output logic [NUM_VC*CNT_W-1:0]     rx_free,
    output logic                        tx_valid,
    output logic                        tx_sop,
    output logic                        tx_eop,
    output logic [VC_W-1:0]             tx_vc,
    output logic [TLP_HEADER_WIDTH-1:0] tx_header,
    output logic [DATA_WIDTH-1:0]       tx_data,
    input  logic                        tx_ready,
    output logic [NUM_VC-1:0]           err_overflow,
    output logic [NUM_VC-1:0]           err_framing,
    input  logic                        err_clr
);
    localparam int PTR_W   = CNT_W - 1;
    localparam int VC_SPAN = 1 << VC_W;

    typedef struct packed {
        logic                        sop;
        logic                        eop;
        logic [TLP_HEADER_WIDTH-1:0] header;
        logic [DATA_WIDTH-1:0]       data;
    } beat_t;

    typedef enum logic {ST_IDLE, ST_PKT} state_e;

    beat_t            mem_q [NUM_VC][DEPTH];
    logic [CNT_W-1:0] wr_ptr_q [NUM_VC];
    logic [CNT_W-1:0] rd_ptr_q [NUM_VC];
    logic [NUM_VC-1:0] in_pkt_q, in_pkt_d;
    logic [NUM_VC-1:0] ovf_q, ovf_d, frm_q, frm_d;
    state_e           state_q, state_d;
    logic [VC_W-1:0]  grant_q, grant_d, last_q, last_d;

    logic [NUM_VC-1:0]  empty, full;
    logic [VC_SPAN-1:0] vc_ok, in_pkt_ext, full_ext;
    logic               rx_hit, frame_ok, wr_en, rd_en, found;
    logic [VC_W-1:0]    rr_vc, sel_vc;
    beat_t              head;
    int                 idx;

    // Occupancy comes from the registered pointers only, so a same-cycle read
    // never frees space for a write.
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            empty[v] = (wr_ptr_q[v] == rd_ptr_q[v]);
            full[v]  = ((wr_ptr_q[v] - rd_ptr_q[v]) == CNT_W'(DEPTH));
            rx_free[v*CNT_W +: CNT_W] = CNT_W'(DEPTH) - (wr_ptr_q[v] - rd_ptr_q[v]);
        end
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        vc_ok      = '0;
        in_pkt_ext = '0;
        full_ext   = '0;
        for (int i = 0; i < VC_SPAN; i++) vc_ok[i] = (i < NUM_VC);
        in_pkt_ext[NUM_VC-1:0] = in_pkt_q;
        full_ext[NUM_VC-1:0]   = full;

        rx_hit   = rx_valid && vc_ok[rx_vc];
        frame_ok = in_pkt_ext[rx_vc] ? !rx_sop : rx_sop;
        wr_en    = rx_hit && frame_ok && !full_ext[rx_vc];

        in_pkt_d = in_pkt_q;
        for (int v = 0; v < NUM_VC; v++) begin
            frm_d[v] = (frm_q[v] && !err_clr) || (rx_hit && rx_vc == VC_W'(v) && !frame_ok);
            ovf_d[v] = (ovf_q[v] && !err_clr) ||
                       (rx_hit && rx_vc == VC_W'(v) && frame_ok && full[v]);
            if (wr_en && rx_vc == VC_W'(v)) in_pkt_d[v] = !rx_eop;
        end
    end

    always_comb begin
        rr_vc = last_q;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NUM_VC; i++) begin
            idx = (int'(last_q) + i) % NUM_VC;
            if (!found && !empty[idx]) begin
                found = 1'b1;
                rr_vc = VC_W'(idx);
            end
        end

        sel_vc    = (state_q == ST_PKT) ? grant_q : rr_vc;
        head      = mem_q[sel_vc][rd_ptr_q[sel_vc][PTR_W-1:0]];
        tx_valid  = !empty[sel_vc];
        tx_vc     = sel_vc;
        tx_sop    = tx_valid && head.sop;
        tx_eop    = tx_valid && head.eop;
        tx_header = head.header;
        tx_data   = head.data;
        rd_en     = tx_valid && tx_ready;

        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        if (rd_en && head.eop) begin
            state_d = ST_IDLE;
            last_d  = sel_vc;
        end else if (tx_valid) begin
            // A stalled head also locks the grant, keeping tx stable until accepted.
            state_d = ST_PKT;
            grant_d = sel_vc;
        end
    end

    // NOTE: beat storage has no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VC; v++) begin
            if (wr_en && rx_vc == VC_W'(v)) begin
                mem_q[v][wr_ptr_q[v][PTR_W-1:0]] <= '{sop: rx_sop, eop: rx_eop,
                                                      header: rx_header, data: rx_data};
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
            end
            in_pkt_q <= '0;
            ovf_q    <= '0;
            frm_q    <= '0;
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            last_q   <= VC_W'(NUM_VC - 1);
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (wr_en && rx_vc == VC_W'(v)) wr_ptr_q[v] <= wr_ptr_q[v] + CNT_W'(1);
                if (rd_en && sel_vc == VC_W'(v)) rd_ptr_q[v] <= rd_ptr_q[v] + CNT_W'(1);
            end
            in_pkt_q <= in_pkt_d;
            ovf_q    <= ovf_d;
            frm_q    <= frm_d;
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
        end
    end

    assign err_overflow = ovf_q;
    assign err_framing  = frm_q;

endmodule
